// File: rtl/led_pulse_driver.sv
// led_pulse_driver: turns a one-cycle press event into a timed,
// optionally PWM-dimmed LED on phase followed by a dark lockout gap.
module led_pulse_driver #(
  parameter int ON_CYCLES  = 6000000,
  parameter int OFF_CYCLES = 3000000,
  parameter int PWM_W      = 4,
  parameter int RETRIG     = 0
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic [PWM_W-1:0] duty,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int ON_W  =
    (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam int GAP_W =
    (OFF_CYCLES > 1) ? $clog2(OFF_CYCLES) : 1;
  localparam int ON_LAST  = ON_CYCLES - 1;
  localparam int GAP_LAST =
    (OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0;
  localparam logic HAS_GAP = (OFF_CYCLES > 0);
  localparam logic CAN_RT  = (RETRIG != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [ON_W-1:0]    on_cnt_q, on_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PWM_W-1:0]   pwm_q, pwm_d;
  logic [PWM_W-1:0]   duty_l_q, duty_l_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               on_last;
  logic               gap_last;

  assign on_last  = (on_cnt_q == ON_W'(ON_LAST));
  assign gap_last = (gap_cnt_q == GAP_W'(GAP_LAST));

  // Next state, counters and the registered LED/busy/done values.
  always_comb begin
    state_d   = state_q;
    on_cnt_d  = on_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pwm_d     = pwm_q;
    duty_l_d  = duty_l_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d  = S_ON;
          on_cnt_d = '0;
          pwm_d    = '0;
          duty_l_d = duty;
        end
      end
      S_ON: begin
        if (CAN_RT && trig) begin
          on_cnt_d = '0;
          pwm_d    = '0;
          duty_l_d = duty;
        end else if (on_last) begin
          on_cnt_d = '0;
          pwm_d    = '0;
          if (HAS_GAP) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          on_cnt_d = on_cnt_q + 1'b1;
          pwm_d    = pwm_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_last) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        on_cnt_d  = '0;
        gap_cnt_d = '0;
        pwm_d     = '0;
      end
    endcase
    led_d  = (state_d == S_ON) &&
             ((duty_l_d == '1) ||
              (pwm_d < duty_l_d));
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      on_cnt_q  <= '0;
      gap_cnt_q <= '0;
      pwm_q     <= '0;
      duty_l_q  <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_cnt_q  <= on_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pwm_q     <= pwm_d;
      duty_l_q  <= duty_l_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_pulse_driver.sv
// tb_led_pulse_driver: random trig/duty/reset stimulus on three
// variants, checked against a phase/remaining-time reference model.
module tb_led_pulse_driver;

  localparam int ONC = 8;
  localparam int PW  = 2;
  localparam int NI  = 3;

  logic          sysclk = 1'b0;
  logic          rst_n;
  logic          trig;
  logic [PW-1:0] duty;
  logic [NI-1:0] led, busy, done;

  int total = 0;
  int bad   = 0;

  int off_c [NI] = '{4, 4, 0};
  int rtg   [NI] = '{0, 1, 0};

  int on_left  [NI];
  int k_idx    [NI];
  int dl       [NI];
  int gap_left [NI];
  int done_m   [NI];

  always #5 sysclk = ~sysclk;

  led_pulse_driver #(
    .ON_CYCLES(ONC), .OFF_CYCLES(4),
    .PWM_W(PW), .RETRIG(0)
  ) u_a (
    .sysclk(sysclk), .rst_n(rst_n),
    .trig(trig), .duty(duty),
    .led(led[0]), .busy(busy[0]),
    .done(done[0])
  );

  led_pulse_driver #(
    .ON_CYCLES(ONC), .OFF_CYCLES(4),
    .PWM_W(PW), .RETRIG(1)
  ) u_b (
    .sysclk(sysclk), .rst_n(rst_n),
    .trig(trig), .duty(duty),
    .led(led[1]), .busy(busy[1]),
    .done(done[1])
  );

  led_pulse_driver #(
    .ON_CYCLES(ONC), .OFF_CYCLES(0),
    .PWM_W(PW), .RETRIG(0)
  ) u_c (
    .sysclk(sysclk), .rst_n(rst_n),
    .trig(trig), .duty(duty),
    .led(led[2]), .busy(busy[2]),
    .done(done[2])
  );

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NI; i++) begin
      on_left[i]  = 0;
      k_idx[i]    = 0;
      dl[i]       = 0;
      gap_left[i] = 0;
      done_m[i]   = 0;
    end
  endtask

  task automatic mdl_step(input int t, input int d);
    for (int i = 0; i < NI; i++) begin
      int nd;
      nd = 0;
      if (on_left[i] > 0) begin
        if (rtg[i] != 0 && t != 0) begin
          on_left[i] = ONC;
          k_idx[i]   = 0;
          dl[i]      = d;
        end else if (on_left[i] == 1) begin
          on_left[i] = 0;
          if (off_c[i] > 0) gap_left[i] = off_c[i];
          else nd = 1;
        end else begin
          on_left[i]--;
          k_idx[i]++;
        end
      end else if (gap_left[i] > 0) begin
        gap_left[i]--;
        if (gap_left[i] == 0) nd = 1;
      end else if (t != 0) begin
        on_left[i] = ONC;
        k_idx[i]   = 0;
        dl[i]      = d;
      end
      done_m[i] = nd;
    end
  endtask

  task automatic chk_all(input string pfx);
    for (int i = 0; i < NI; i++) begin
      int el, eb;
      el = (on_left[i] > 0) &&
           (dl[i] == 3 || (k_idx[i] % 4) < dl[i]);
      eb = (on_left[i] > 0) || (gap_left[i] > 0);
      chk($sformatf("%s_led%0d", pfx, i),
          int'(led[i]), el);
      chk($sformatf("%s_busy%0d", pfx, i),
          int'(busy[i]), eb);
      chk($sformatf("%s_done%0d", pfx, i),
          int'(done[i]), done_m[i]);
    end
  endtask

  initial begin
    int mode;
    rst_n = 1'b0;
    trig  = 1'b0;
    duty  = '0;
    mdl_reset();
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk_all("rst");
    rst_n = 1'b1;
    mode  = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge sysclk);
      chk_all("run");
      if (c % 60 == 0) mode = $urandom_range(0, 3);
      unique case (mode)
        0: trig = ($urandom_range(0, 15) == 0);
        1: trig = ($urandom_range(0, 3) == 0);
        2: trig = 1'b1;
        default: trig = ($urandom_range(0, 1) == 0);
      endcase
      duty = PW'($urandom_range(0, 3));
      if (c % 97 == 50) begin
        @(posedge sysclk);
        mdl_step(int'(trig), int'(duty));
        #2;
        rst_n = 1'b0;
        #1;
        mdl_reset();
        chk_all("arst");
        trig = 1'b0;
        @(negedge sysclk);
        chk_all("arst_hold");
        rst_n = 1'b1;
      end else begin
        @(posedge sysclk);
        mdl_step(int'(trig), int'(duty));
      end
    end
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
